lasers_sweep_obstacle: RTL and testbench



---
 rtl/obstacle_pkg.sv | 27 ++
 rtl/lasers_step_timer.sv | 31 +++
 rtl/lasers_sweep_obstacle.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lasers_sweep_obstacle.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle chain: FSM state encoding, sweep
// direction, default colours and screen coordinate limits.
package obstacle_pkg;

  // Phase of an obstacle sweep
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_GROW  = 2'd2,
    ST_HOLD  = 2'd3
  } obs_state_e;

  // Direction the sweep walks through the laser columns
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // Pixel coordinate width and the largest representable coordinate
  localparam int COORD_W   = 12;
  localparam int COORD_MAX = 4095;

  // Colours
  localparam logic [11:0] LASER_COLOR_DEF = 12'hfff;
  localparam logic [11:0] WARN_COLOR      = 12'hf00;

endpackage

// File: rtl/lasers_step_timer.sv
// Loadable down-counter shared by the SPAWN, GROW and HOLD phases.
// Loading value V makes tc rise V cycles later; tc stays high at zero until
// the next load.
module lasers_step_timer #(
  parameter int W = 8
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Count down from the loaded value and park at zero
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == {W{1'b0}});

endmodule

// File: rtl/lasers_sweep_obstacle.sv
// N evenly spaced vertical lasers swept forward then in reverse. Each laser
// spawns 2 px wide, waits, grows 1 px per side per step up to MAX_HALF,
// holds, then hands over to the next laser.
// Optional macro LASERS_WARN_EN: the SPAWN phase is drawn in WARN_COLOR and
// is not lethal.
module lasers_sweep_obstacle
  import obstacle_pkg::*;
#(
  parameter int          N_LASERS    = 3,
  parameter int          FIRST_X     = 411,
  parameter int          PITCH       = 100,
  parameter int          TOP_Y       = 317,
  parameter int          BOTTOM_Y    = 617,
  parameter int          MAX_HALF    = 30,
  parameter int          SPAWN_DELAY = 32000000,
  parameter int          GROW_DELAY  = 3200000,
  parameter int          HOLD_DELAY  = 32000000,
  parameter logic [3:0]  SELECT_CODE = 4'b0001,
  parameter logic [11:0] LASER_COLOR = LASER_COLOR_DEF
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic [11:0]        rgb_in,
  input  logic               menu_on,
  input  logic               play_selected,
  input  logic [3:0]         selected,
  input  logic               done_control,
  output logic               working,
  output logic               done,
  output logic [11:0]        rgb_out,
  output logic [COORD_W-1:0] obstacle_x,
  output logic [COORD_W-1:0] obstacle_y,
  output logic [2:0]         laser_idx
);

  localparam int MAX_DELAY =
    (SPAWN_DELAY > GROW_DELAY) ?
      ((SPAWN_DELAY > HOLD_DELAY) ? SPAWN_DELAY : HOLD_DELAY) :
      ((GROW_DELAY  > HOLD_DELAY) ? GROW_DELAY  : HOLD_DELAY);
  localparam int CNT_W  = $clog2(MAX_DELAY) + 1;
  localparam int STEP_W = $clog2(MAX_HALF + 1) + 1;

  // Timer reload values: a phase of D cycles loads D-1
  localparam logic [CNT_W-1:0]   SPAWN_LOAD = CNT_W'(SPAWN_DELAY - 1);
  localparam logic [CNT_W-1:0]   GROW_LOAD  = CNT_W'(GROW_DELAY - 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_DELAY - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(MAX_HALF);
  localparam logic [2:0]         LAST_IDX   = 3'(N_LASERS - 1);
  localparam logic [COORD_W-1:0] TOP_ROW    = COORD_W'(TOP_Y);
  localparam logic [COORD_W-1:0] BOT_ROW    = COORD_W'(BOTTOM_Y);
  localparam logic [COORD_W-1:0] ONE_PX     = {{(COORD_W-1){1'b0}}, 1'b1};

  // Reject geometry that would wrap the 12-bit coordinate space
  generate
    if ((N_LASERS < 1) || (N_LASERS > 8) || (MAX_HALF < 1) ||
        (SPAWN_DELAY < 1) || (GROW_DELAY < 1) || (HOLD_DELAY < 1) ||
        (FIRST_X < MAX_HALF) ||
        (FIRST_X + (N_LASERS - 1) * PITCH + 1 + MAX_HALF > COORD_MAX)) begin : g_param_check
      $error("lasers_sweep_obstacle: illegal parameter set");
    end
  endgenerate

  // Left edge of laser idx at spawn width, computed modulo 2^12
  function automatic logic [COORD_W-1:0] spawn_left(input logic [2:0] idx);
    return COORD_W'(FIRST_X) + (COORD_W'(PITCH) * {{(COORD_W-3){1'b0}}, idx});
  endfunction

  obs_state_e          state_r, state_n;
  dir_e                dir_r, dir_n;
  logic                rep_r, rep_n;
  logic [2:0]          idx_r, idx_n;
  logic [COORD_W-1:0]  left_r, left_n;
  logic [COORD_W-1:0]  right_r, right_n;
  logic [STEP_W-1:0]   step_r, step_n;
  logic                working_r, done_r, done_n;
  logic                tmr_load_s, tmr_tc_s;
  logic [CNT_W-1:0]    tmr_value_s;
  logic                start_s, abort_s;
  logic                hit_s;
  logic [11:0]         rgb_n, rgb_r;
  logic [COORD_W-1:0]  obs_x_n, obs_y_n, obs_x_r, obs_y_r;

  assign start_s = done_control && play_selected && (selected == SELECT_CODE) && !menu_on;
  assign abort_s = menu_on || !play_selected;

  lasers_step_timer #(
    .W (CNT_W)
  ) u_timer (
    .pclk       (pclk),
    .rst        (rst),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .tc         (tmr_tc_s)
  );

  // Next-state logic: phase sequencing, laser geometry and sweep order
  always_comb begin
    state_n     = state_r;
    dir_n       = dir_r;
    rep_n       = rep_r;
    idx_n       = idx_r;
    left_n      = left_r;
    right_n     = right_r;
    step_n      = step_r;
    done_n      = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_value_s = SPAWN_LOAD;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_n     = ST_SPAWN;
          dir_n       = DIR_FWD;
          rep_n       = 1'b0;
          idx_n       = 3'd0;
          left_n      = spawn_left(3'd0);
          right_n     = spawn_left(3'd0) + ONE_PX;
          step_n      = {STEP_W{1'b0}};
          tmr_load_s  = 1'b1;
          tmr_value_s = SPAWN_LOAD;
        end else begin
          idx_n = 3'd0;
        end
      end
      ST_SPAWN: begin
        if (abort_s) begin
          state_n = ST_IDLE;
          idx_n   = 3'd0;
        end else if (tmr_tc_s) begin
          // First growth step coincides with entering GROW
          state_n     = ST_GROW;
          left_n      = left_r - ONE_PX;
          right_n     = right_r + ONE_PX;
          step_n      = STEP_ONE;
          tmr_load_s  = 1'b1;
          tmr_value_s = GROW_LOAD;
        end else begin
          state_n = ST_SPAWN;
        end
      end
      ST_GROW: begin
        if (abort_s) begin
          state_n = ST_IDLE;
          idx_n   = 3'd0;
        end else if (tmr_tc_s) begin
          if (step_r == STEP_LAST) begin
            state_n     = ST_HOLD;
            tmr_load_s  = 1'b1;
            tmr_value_s = HOLD_LOAD;
          end else begin
            left_n      = left_r - ONE_PX;
            right_n     = right_r + ONE_PX;
            step_n      = step_r + STEP_ONE;
            tmr_load_s  = 1'b1;
            tmr_value_s = GROW_LOAD;
          end
        end else begin
          state_n = ST_GROW;
        end
      end
      ST_HOLD: begin
        if (abort_s) begin
          state_n = ST_IDLE;
          idx_n   = 3'd0;
        end else if (tmr_tc_s) begin
          if ((dir_r == DIR_REV) && (idx_r == 3'd0)) begin
            state_n = ST_IDLE;
            idx_n   = 3'd0;
            done_n  = 1'b1;
          end else begin
            if ((dir_r == DIR_FWD) && (idx_r != LAST_IDX)) begin
              idx_n = idx_r + 3'd1;
            end else if ((dir_r == DIR_FWD) && !rep_r) begin
              idx_n = idx_r;
              rep_n = 1'b1;
              dir_n = DIR_REV;
            end else begin
              idx_n = idx_r - 3'd1;
            end
            state_n     = ST_SPAWN;
            left_n      = spawn_left(idx_n);
            right_n     = spawn_left(idx_n) + ONE_PX;
            step_n      = {STEP_W{1'b0}};
            tmr_load_s  = 1'b1;
            tmr_value_s = SPAWN_LOAD;
          end
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = 3'd0;
      end
    endcase
  end

  // FSM and sweep-context registers; working/done follow the next state
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      dir_r     <= DIR_FWD;
      rep_r     <= 1'b0;
      idx_r     <= 3'd0;
      left_r    <= {COORD_W{1'b0}};
      right_r   <= {COORD_W{1'b0}};
      step_r    <= {STEP_W{1'b0}};
      working_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      dir_r     <= dir_n;
      rep_r     <= rep_n;
      idx_r     <= idx_n;
      left_r    <= left_n;
      right_r   <= right_n;
      step_r    <= step_n;
      working_r <= (state_n != ST_IDLE);
      done_r    <= done_n;
    end
  end

  // Pixel hit test against the current laser rectangle
  always_comb begin
    hit_s   = (state_r != ST_IDLE) &&
              (hcount_in >= left_r) && (hcount_in <= right_r) &&
              (vcount_in >= TOP_ROW) && (vcount_in <= BOT_ROW);
    rgb_n   = rgb_in;
    obs_x_n = {COORD_W{1'b0}};
    obs_y_n = {COORD_W{1'b0}};
    if (hit_s) begin
`ifdef LASERS_WARN_EN
      if (state_r == ST_SPAWN) begin
        rgb_n = WARN_COLOR;
      end else begin
        rgb_n   = LASER_COLOR;
        obs_x_n = hcount_in;
        obs_y_n = vcount_in;
      end
`else
      rgb_n   = LASER_COLOR;
      obs_x_n = hcount_in;
      obs_y_n = vcount_in;
`endif
    end else begin
      rgb_n = rgb_in;
    end
  end

  // Register the pixel outputs (one cycle of latency)
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb_r   <= 12'h000;
      obs_x_r <= {COORD_W{1'b0}};
      obs_y_r <= {COORD_W{1'b0}};
    end else begin
      rgb_r   <= rgb_n;
      obs_x_r <= obs_x_n;
      obs_y_r <= obs_y_n;
    end
  end

  assign working    = working_r;
  assign done       = done_r;
  assign laser_idx  = idx_r;
  assign rgb_out    = rgb_r;
  assign obstacle_x = obs_x_r;
  assign obstacle_y = obs_y_r;

endmodule

// File: tb/tb_lasers_sweep_obstacle.sv
// Self-checking bench for lasers_sweep_obstacle with short delays
// (phase = 4 spawn + 3*2 grow + 3 hold = 13 cycles, sweep of 6 phases).
module tb_lasers_sweep_obstacle;

  localparam int N  = 3;
  localparam int SD = 4;
  localparam int GD = 2;
  localparam int HD = 3;
  localparam int MH = 3;
  localparam int FX = 411;
  localparam int PT = 100;
  localparam int TY = 317;
  localparam int BY = 617;
  localparam int PH = SD + MH * GD + HD;
  localparam int SWEEP = 2 * N * PH;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hcount_in = 12'd0;
  logic [11:0] vcount_in = 12'd0;
  logic [11:0] rgb_in = 12'h000;
  logic        menu_on = 1'b0;
  logic        play_selected = 1'b0;
  logic [3:0]  selected = 4'd0;
  logic        done_control = 1'b0;
  logic        working, done;
  logic [11:0] rgb_out, obstacle_x, obstacle_y;
  logic [2:0]  laser_idx;

  int n_checks = 0;
  int n_pass = 0;

  lasers_sweep_obstacle #(
    .N_LASERS(N), .SPAWN_DELAY(SD), .GROW_DELAY(GD), .HOLD_DELAY(HD), .MAX_HALF(MH)
  ) dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .rgb_in(rgb_in), .menu_on(menu_on), .play_selected(play_selected),
    .selected(selected), .done_control(done_control), .working(working),
    .done(done), .rgb_out(rgb_out), .obstacle_x(obstacle_x),
    .obstacle_y(obstacle_y), .laser_idx(laser_idx)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [3:0]  sel;
    logic        dc, play, menu;
    logic [11:0] h, v, rgb;
    logic [11:0] exp_rgb, exp_x, exp_y;
  } idle_vec_t;

  typedef struct {
    int t, h, v, er, ex, ey;
  } pix_vec_t;

  idle_vec_t ivec[6];
  pix_vec_t  dvec[10];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Which laser is visited in cycle t of the sweep
  function automatic int model_idx(input int t);
    int p;
    p = t / PH;
    return (p < N) ? p : (2 * N - 1 - p);
  endfunction

  // Expected pixel outputs for a pixel presented while the sweep was at cycle t
  task automatic predict(input int t, input int h, input int v, input int rgbi,
                         output int er, output int ex, output int ey);
    int o, base, half;
    bit hit, warn;
    er = rgbi; ex = 0; ey = 0;
    if (t >= 0 && t < SWEEP) begin
      o = t % PH;
      base = FX + model_idx(t) * PT;
      if (o < SD) half = 0;
      else if (o < SD + MH * GD) half = (o - SD) / GD + 1;
      else half = MH;
      hit = (h >= base - half) && (h <= base + 1 + half) && (v >= TY) && (v <= BY);
      warn = 1'b0;
`ifdef LASERS_WARN_EN
      warn = (o < SD);
`endif
      if (hit && warn) er = 'hf00;
      else if (hit) begin er = 'hfff; ex = h; ey = v; end
    end
  endtask

  task automatic start_sweep();
    done_control = 1'b1; selected = 4'd1; play_selected = 1'b1; menu_on = 1'b0;
    tick();
    done_control = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_working"}, int'(working), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rgb"}, int'(rgb_out), 0);
    check({tag, "_x"}, int'(obstacle_x), 0);
    check({tag, "_y"}, int'(obstacle_y), 0);
    check({tag, "_idx"}, int'(laser_idx), 0);
  endtask

  initial begin
    int pt, ph, pv, prgb, pdir, er, ex, ey, done_seen, work_seen;

    ivec[0] = '{4'd2, 1'b1, 1'b1, 1'b0, 12'd411, 12'd400, 12'h123, 12'h123, 12'd0, 12'd0};
    ivec[1] = '{4'd1, 1'b1, 1'b1, 1'b1, 12'd412, 12'd317, 12'h0a5, 12'h0a5, 12'd0, 12'd0};
    ivec[2] = '{4'd1, 1'b1, 1'b0, 1'b0, 12'd511, 12'd617, 12'h3c3, 12'h3c3, 12'd0, 12'd0};
    ivec[3] = '{4'd1, 1'b0, 1'b1, 1'b0, 12'd611, 12'd500, 12'h777, 12'h777, 12'd0, 12'd0};
    ivec[4] = '{4'd0, 1'b1, 1'b1, 1'b0, 12'd411, 12'd500, 12'h00f, 12'h00f, 12'd0, 12'd0};
    ivec[5] = '{4'd3, 1'b1, 1'b1, 1'b0, 12'd412, 12'd318, 12'hfff, 12'hfff, 12'd0, 12'd0};

`ifdef LASERS_WARN_EN
    dvec[0] = '{1, 411, 400, 'hf00, 0, 0};
`else
    dvec[0] = '{1, 411, 400, 'hfff, 411, 400};
`endif
    dvec[1] = '{3, 410, 400, 'h0a0, 0, 0};
    dvec[2] = '{4, 410, 400, 'hfff, 410, 400};
    dvec[3] = '{23, 508, 317, 'hfff, 508, 317};
    dvec[4] = '{24, 515, 617, 'hfff, 515, 617};
    dvec[5] = '{25, 507, 400, 'h0a0, 0, 0};
    dvec[6] = '{62, 512, 618, 'h0a0, 0, 0};
    dvec[7] = '{63, 511, 316, 'h0a0, 0, 0};
    dvec[8] = '{64, 514, 500, 'hfff, 514, 500};
    dvec[9] = '{78, 415, 317, 'h0a0, 0, 0};

    // Reset state
    tick(); tick();
    check_zero_outputs("reset");
    @(negedge pclk);
    rst = 1'b0;

    // No start unless every start condition holds
    for (int i = 0; i < 6; i++) begin
      selected = ivec[i].sel; done_control = ivec[i].dc;
      play_selected = ivec[i].play; menu_on = ivec[i].menu;
      hcount_in = ivec[i].h; vcount_in = ivec[i].v; rgb_in = ivec[i].rgb;
      tick();
      check($sformatf("idle%0d_rgb", i), int'(rgb_out), int'(ivec[i].exp_rgb));
      check($sformatf("idle%0d_x", i), int'(obstacle_x), int'(ivec[i].exp_x));
      check($sformatf("idle%0d_y", i), int'(obstacle_y), int'(ivec[i].exp_y));
      check($sformatf("idle%0d_working", i), int'(working), 0);
      check($sformatf("idle%0d_idx", i), int'(laser_idx), 0);
    end
    done_control = 1'b0; menu_on = 1'b0; play_selected = 1'b1;

    // Full sweep with random pixels against the model, plus directed pixels
    hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'h555;
    pt = -1; ph = 0; pv = 0; prgb = 'h555; pdir = -1;
    start_sweep();
    for (int k = 0; k <= SWEEP + 1; k++) begin
      check($sformatf("sweep_working_t%0d", k), int'(working), (k < SWEEP) ? 1 : 0);
      check($sformatf("sweep_idx_t%0d", k), int'(laser_idx), (k < SWEEP) ? model_idx(k) : 0);
      check($sformatf("sweep_done_t%0d", k), int'(done), (k == SWEEP) ? 1 : 0);
      predict(pt, ph, pv, prgb, er, ex, ey);
      check($sformatf("sweep_rgb_t%0d", k), int'(rgb_out), er);
      check($sformatf("sweep_x_t%0d", k), int'(obstacle_x), ex);
      check($sformatf("sweep_y_t%0d", k), int'(obstacle_y), ey);
      if (pdir >= 0) begin
        check($sformatf("pix_rgb_t%0d", dvec[pdir].t), int'(rgb_out), dvec[pdir].er);
        check($sformatf("pix_x_t%0d", dvec[pdir].t), int'(obstacle_x), dvec[pdir].ex);
        check($sformatf("pix_y_t%0d", dvec[pdir].t), int'(obstacle_y), dvec[pdir].ey);
      end
      pdir = -1;
      for (int j = 0; j < 10; j++) if (dvec[j].t == k) pdir = j;
      if (pdir >= 0) begin
        hcount_in = 12'(dvec[pdir].h); vcount_in = 12'(dvec[pdir].v); rgb_in = 12'h0a0;
      end else begin
        hcount_in = 12'(400 + $urandom_range(0, 260));
        vcount_in = 12'(300 + $urandom_range(0, 340));
        rgb_in = 12'($urandom_range(0, 4095));
      end
      pt = k; ph = int'(hcount_in); pv = int'(vcount_in); prgb = int'(rgb_in);
      tick();
    end

    // menu_on mid-GROW of laser 2 aborts without done
    start_sweep();
    for (int i = 0; i < 32; i++) tick();
    check("abort_pre_idx", int'(laser_idx), 2);
    check("abort_pre_working", int'(working), 1);
    menu_on = 1'b1;
    tick();
    check("abort_working", int'(working), 0);
    check("abort_idx", int'(laser_idx), 0);
    check("abort_done", int'(done), 0);
    menu_on = 1'b0;
    done_seen = 0; work_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) done_seen++;
      if (working) work_seen++;
    end
    check("abort_done_seen", done_seen, 0);
    check("abort_work_seen", work_seen, 0);
    start_sweep();
    check("restart_idx", int'(laser_idx), 0);
    check("restart_working", int'(working), 1);
    for (int i = 0; i < 12; i++) tick();
    check("restart_idx_t12", int'(laser_idx), 0);
    check("restart_working_t12", int'(working), 1);
    // play_selected drop on the cycle laser 0 would hand over
    play_selected = 1'b0;
    tick();
    check("playdrop_working", int'(working), 0);
    check("playdrop_idx", int'(laser_idx), 0);
    check("playdrop_done", int'(done), 0);
    play_selected = 1'b1;
    tick();

    // Asynchronous reset between clock edges during laser 0 HOLD
    start_sweep();
    for (int i = 0; i < 11; i++) tick();
    hcount_in = 12'd411; vcount_in = 12'd400; rgb_in = 12'h0a0;
    tick();
    check("prerst_working", int'(working), 1);
    check("prerst_rgb", int'(rgb_out), 'hfff);
    check("prerst_x", int'(obstacle_x), 411);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    tick();
    @(negedge pclk);
    rst = 1'b0;
    done_seen = 0; work_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
      if (working) work_seen++;
    end
    check("postrst_done_seen", done_seen, 0);
    check("postrst_work_seen", work_seen, 0);
    check("postrst_idx", int'(laser_idx), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
